// File: rtl/pipeline_hazard_controller.sv
// Pipeline stall/flush sequencer: load-use and RAW hazard detection, SRAM
// wait-state sequencing for the MEM stage, and branch flush arbitration.
module pipeline_hazard_controller #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_uses_src1,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_rd_en,
  input  logic             mem_wr_en,
  input  logic             branch_taken,
  output logic             sram_start,
  output logic             mem_freeze,
  output logic             hazard_stall,
  output logic             bubble_id_exe,
  output logic             flush_if_id,
  output logic             mem_data_valid,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned WC_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wcnt, wcnt_nxt;
  logic            mem_req;
  logic            s1_exe, s2_exe, s1_mem, s2_mem;
  logic            haz_load_use, haz_raw, hazard;

  assign mem_req = mem_rd_en | mem_wr_en;

  // Source/destination matches, qualified by whether the ID instruction reads the source
  assign s1_exe = id_uses_src1 & (id_src1 == exe_dest);
  assign s2_exe = id_two_src   & (id_src2 == exe_dest);
  assign s1_mem = id_uses_src1 & (id_src1 == mem_dest);
  assign s2_mem = id_two_src   & (id_src2 == mem_dest);

  assign haz_load_use = exe_mem_read & exe_wb_en & (s1_exe | s2_exe);
  assign haz_raw      = (exe_wb_en & (s1_exe | s2_exe)) | (mem_wb_en & (s1_mem | s2_mem));
  assign hazard       = forward_en ? haz_load_use : haz_raw;

  // State, wait counter and saturating stall statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if ((mem_freeze | hazard_stall) && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  // Next state and control strobes; freeze outranks flush, flush outranks stall
  always_comb begin
    state_nxt      = state;
    wcnt_nxt       = wcnt;
    sram_start     = 1'b0;
    mem_freeze     = 1'b0;
    mem_data_valid = 1'b0;
    hazard_stall   = 1'b0;
    flush_if_id    = 1'b0;
    bubble_id_exe  = 1'b0;

    case (state)
      S_IDLE: begin
        if (mem_req) begin
          sram_start = 1'b1;
          mem_freeze = 1'b1;
          state_nxt  = S_WAIT;
          wcnt_nxt   = WC_W'(WAIT_CYCLES - 1);
        end
      end
      S_WAIT: begin
        mem_freeze = 1'b1;
        if (wcnt == '0) state_nxt = S_DONE;
        else            wcnt_nxt  = wcnt - WC_W'(1);
      end
      S_DONE: begin
        mem_data_valid = mem_rd_en;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    flush_if_id   = branch_taken & ~mem_freeze;
    hazard_stall  = hazard & ~mem_freeze & ~branch_taken;
    bubble_id_exe = hazard_stall | flush_if_id;
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: per-cycle expected strobes are
// queued when stimulus is applied and checked against the DUT mid-cycle.
module tb_pipeline_hazard_controller;

  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] CMAX = '1;

  // {sram_start, mem_freeze, hazard_stall, bubble_id_exe, flush_if_id, mem_data_valid}
  localparam logic [5:0] C_NONE    = 6'b000000;
  localparam logic [5:0] C_START   = 6'b110000;
  localparam logic [5:0] C_FRZ     = 6'b010000;
  localparam logic [5:0] C_DONE    = 6'b000000;
  localparam logic [5:0] C_DONE_RD = 6'b000001;
  localparam logic [5:0] C_STALL   = 6'b001100;
  localparam logic [5:0] C_FLUSH   = 6'b000110;
  localparam logic [5:0] C_DRD_FL  = 6'b000111;

  typedef struct packed {
    logic [5:0]    ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic forward_en, id_two_src, id_uses_src1, exe_wb_en, exe_mem_read;
  logic mem_wb_en, mem_rd_en, mem_wr_en, branch_taken;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic sram_start, mem_freeze, hazard_stall, bubble_id_exe, flush_if_id, mem_data_valid;
  logic [CW-1:0] stall_count;

  exp_t      sb[$];
  int        total = 0;
  int        bad = 0;
  logic [CW-1:0] exp_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.WAIT_CYCLES(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_uses_src1(id_uses_src1), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .branch_taken(branch_taken),
    .sram_start(sram_start), .mem_freeze(mem_freeze), .hazard_stall(hazard_stall),
    .bubble_id_exe(bubble_id_exe), .flush_if_id(flush_if_id),
    .mem_data_valid(mem_data_valid), .stall_count(stall_count)
  );

  task automatic clear_inputs();
    forward_en = 1'b1; id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
    id_uses_src1 = 1'b0; exe_dest = 4'hf; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
    mem_dest = 4'he; mem_wb_en = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    branch_taken = 1'b0;
  endtask

  // Queue expectation, check mid-cycle, advance the count model, move past the next edge.
  task automatic step(input logic [5:0] ctl, input string tag);
    exp_t e;
    logic [5:0] got;
    sb.push_back('{ctl: ctl, cnt: exp_cnt});
    @(negedge clk);
    e   = sb.pop_front();
    got = {sram_start, mem_freeze, hazard_stall, bubble_id_exe, flush_if_id, mem_data_valid};
    total++;
    assert (got === e.ctl) else begin
      bad++;
      $error("FAIL %s ctl got=%b exp=%b", tag, got, e.ctl);
    end
    total++;
    assert (stall_count === e.cnt) else begin
      bad++;
      $error("FAIL %s stall_count got=%0d exp=%0d", tag, stall_count, e.cnt);
    end
    if (rst) exp_cnt = '0;
    else if ((ctl[4] | ctl[3]) && exp_cnt != CMAX) exp_cnt = exp_cnt + CW'(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    exp_cnt = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(C_NONE, "reset_idle");

    // Single load: 5 frozen cycles, then DONE with read data valid
    mem_rd_en = 1'b1;
    step(C_START, "ld_start");
    for (int i = 0; i < 4; i++) step(C_FRZ, "ld_wait");
    step(C_DONE_RD, "ld_done");
    mem_rd_en = 1'b0;
    step(C_NONE, "ld_after_cnt5");

    // Back-to-back stores: starts 6 cycles apart, one unfrozen cycle between
    mem_wr_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(C_START, "st_start");
      for (int i = 0; i < 4; i++) step(C_FRZ, "st_wait");
      step(C_DONE, "st_done");
    end
    mem_wr_en = 1'b0;
    step(C_NONE, "st_after");

    // Load-use with forwarding
    forward_en = 1'b1; exe_mem_read = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3;
    id_src1 = 4'd3; id_uses_src1 = 1'b1;
    step(C_STALL, "lu_src1");
    id_uses_src1 = 1'b0; id_src1 = 4'd0; id_src2 = 4'd3; id_two_src = 1'b0;
    step(C_NONE, "lu_src2_unused");
    id_two_src = 1'b1;
    step(C_STALL, "lu_src2_used");
    exe_mem_read = 1'b0;
    step(C_NONE, "fwd_alu_no_stall");
    clear_inputs();

    // RAW dependency without forwarding
    forward_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd7; id_src2 = 4'd7; id_two_src = 1'b1;
    step(C_STALL, "raw_mem_src2");
    forward_en = 1'b1;
    step(C_NONE, "raw_mem_fwd_on");
    clear_inputs();
    forward_en = 1'b0; exe_wb_en = 1'b1; exe_dest = 4'd5; id_src1 = 4'd5; id_uses_src1 = 1'b1;
    step(C_STALL, "raw_exe_src1");
    exe_wb_en = 1'b0;
    step(C_NONE, "raw_exe_no_wb");
    clear_inputs();

    // Branch alone flushes immediately
    branch_taken = 1'b1;
    step(C_FLUSH, "br_idle");

    // Branch plus load-use during an SRAM access: flush deferred to DONE, stall suppressed
    forward_en = 1'b1; exe_mem_read = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3;
    id_src1 = 4'd3; id_uses_src1 = 1'b1; mem_rd_en = 1'b1;
    step(C_START, "br_ld_start");
    for (int i = 0; i < 4; i++) step(C_FRZ, "br_ld_wait");
    step(C_DRD_FL, "br_ld_done");
    clear_inputs();
    step(C_NONE, "br_after");

    // Drive the counter into saturation with a standing hazard
    forward_en = 1'b0; exe_wb_en = 1'b1; exe_dest = 4'd9; id_src1 = 4'd9; id_uses_src1 = 1'b1;
    for (int i = 0; i < 12; i++) step(C_STALL, "sat_stall");
    clear_inputs();
    step(C_NONE, "sat_hold");

    // Reset while in WAIT with counter at 2
    mem_wr_en = 1'b1;
    step(C_START, "rst_start");
    step(C_FRZ, "rst_wait_c3");
    rst = 1'b1;
    step(C_FRZ, "rst_wait_c2");
    rst = 1'b0; mem_wr_en = 1'b0;
    step(C_NONE, "rst_after_idle");
    step(C_NONE, "rst_no_valid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
